// File: rtl/minimac_pkg.sv
// Shared encodings for the minimac packet buffer: controller states and the
// grant identifiers used by the round-robin arbiter.
package minimac_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_RX  = 2'd0,
    GNT_TX  = 2'd1,
    GNT_CPU = 2'd2
  } gnt_t;

  // Round-robin pick in the fixed order RX, TX, CPU, starting after 'last'.
  // req bit 0 = RX, bit 1 = TX, bit 2 = CPU. Callers only use the result
  // when at least one request bit is set.
  function automatic gnt_t rr_pick(input gnt_t last, input logic [2:0] req);
    case (last)
      GNT_RX:  rr_pick = req[1] ? GNT_TX  : (req[2] ? GNT_CPU : GNT_RX);
      GNT_TX:  rr_pick = req[2] ? GNT_CPU : (req[0] ? GNT_RX  : GNT_TX);
      default: rr_pick = req[0] ? GNT_RX  : (req[1] ? GNT_TX  : GNT_CPU);
    endcase
  endfunction

endpackage

// File: rtl/minimac_pktram_mem.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a
// registered read port, written so synthesis maps it onto block RAM.
module minimac_pktram_mem #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and read-before-write output register, both gated by en.
  // NOTE: the array has no reset on purpose; a reset port would stop the
  // tools from mapping it onto block RAM, and packet contents need none.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/minimac_pktram.sv
// Packet buffer shared by the MAC RX DMA (write), the MAC TX DMA (read) and
// the CPU (read/write). One single-port RAM, a three-state access controller
// and a round-robin arbiter; every access takes IDLE -> ACCESS -> ACK.
module minimac_pktram
  import minimac_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        sys_clk,
  input  logic        sys_rst,

  input  logic [31:0] wbrx_adr_i,
  input  logic [31:0] wbrx_dat_i,
  input  logic        wbrx_cyc_i,
  input  logic        wbrx_stb_i,
  output logic        wbrx_ack_o,

  input  logic [31:0] wbtx_adr_i,
  input  logic        wbtx_cyc_i,
  input  logic        wbtx_stb_i,
  output logic        wbtx_ack_o,
  output logic [31:0] wbtx_dat_o,

  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  state_t                state;
  gnt_t                  grant;
  gnt_t                  last_grant;
  logic                  rd_tx;
  logic                  rd_cpu;
  logic [31:0]           tx_hold;
  logic [31:0]           cpu_hold;
  logic [2:0]            req;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_q;

  // Only adr[ADDR_WIDTH+1:2] is decoded; the remaining address bits alias.
  logic                  unused_adr_bits;
  assign unused_adr_bits = ^{wbrx_adr_i, wbtx_adr_i, wb_adr_i};

  assign req = {wb_cyc_i & wb_stb_i, wbtx_cyc_i & wbtx_stb_i, wbrx_cyc_i & wbrx_stb_i};

  // Controller: arbitrate in IDLE, run the RAM cycle in ACCESS, ack in ACK.
  // Read data stays in the RAM output register through ACK and is copied into
  // the owning port's hold register as ACK ends.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      grant      <= GNT_RX;
      last_grant <= GNT_CPU;
      rd_tx      <= 1'b0;
      rd_cpu     <= 1'b0;
      tx_hold    <= '0;
      cpu_hold   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant      <= rr_pick(last_grant, req);
            last_grant <= rr_pick(last_grant, req);
            state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rd_tx  <= (grant == GNT_TX);
          rd_cpu <= (grant == GNT_CPU) && !wb_we_i;
          state  <= S_ACK;
        end
        S_ACK: begin
          if (rd_tx)  tx_hold  <= ram_q;
          if (rd_cpu) cpu_hold <= ram_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM request mux: drive the granted port's address/data/enables in ACCESS.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == S_ACCESS) begin
      ram_en = 1'b1;
      case (grant)
        GNT_RX: begin
          ram_addr  = wbrx_adr_i[ADDR_WIDTH+1:2];
          ram_wdata = wbrx_dat_i;
          ram_we    = 4'b1111;
        end
        GNT_TX: begin
          ram_addr  = wbtx_adr_i[ADDR_WIDTH+1:2];
        end
        default: begin
          ram_addr  = wb_adr_i[ADDR_WIDTH+1:2];
          ram_wdata = wb_dat_i;
          ram_we    = wb_we_i ? wb_sel_i : 4'b0000;
        end
      endcase
    end
  end

  // Acks: only in ACK, only for the granted port, and only while it still strobes.
  assign wbrx_ack_o = !sys_rst && (state == S_ACK) && (grant == GNT_RX)  && req[0];
  assign wbtx_ack_o = !sys_rst && (state == S_ACK) && (grant == GNT_TX)  && req[1];
  assign wb_ack_o   = !sys_rst && (state == S_ACK) && (grant == GNT_CPU) && req[2];

  // Read data: fresh RAM output during the port's own ACK, held value otherwise.
  assign wbtx_dat_o = (!sys_rst && state == S_ACK && rd_tx)  ? ram_q : tx_hold;
  assign wb_dat_o   = (!sys_rst && state == S_ACK && rd_cpu) ? ram_q : cpu_hold;

  minimac_pktram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (sys_clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_minimac_pktram.sv
// Directed bench for minimac_pktram: a scoreboard queue holds the expected
// ack (port, cycle, read data) for each request and is drained as acks arrive.
module tb_minimac_pktram;
  import minimac_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wbrx_adr_i, wbrx_dat_i;
  logic        wbrx_cyc_i, wbrx_stb_i, wbrx_ack_o;
  logic [31:0] wbtx_adr_i, wbtx_dat_o;
  logic        wbtx_cyc_i, wbtx_stb_i, wbtx_ack_o;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          port;     // 0 RX, 1 TX, 2 CPU
    int          exp_cyc;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  minimac_pktram dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wbrx_adr_i (wbrx_adr_i),
    .wbrx_dat_i (wbrx_dat_i),
    .wbrx_cyc_i (wbrx_cyc_i),
    .wbrx_stb_i (wbrx_stb_i),
    .wbrx_ack_o (wbrx_ack_o),
    .wbtx_adr_i (wbtx_adr_i),
    .wbtx_cyc_i (wbtx_cyc_i),
    .wbtx_stb_i (wbtx_stb_i),
    .wbtx_ack_o (wbtx_ack_o),
    .wbtx_dat_o (wbtx_dat_o),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_ack_o   (wb_ack_o)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drop_all;
    wbrx_cyc_i = 1'b0; wbrx_stb_i = 1'b0;
    wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0;
    wb_cyc_i   = 1'b0; wb_stb_i   = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic req_rx(input logic [31:0] adr, input logic [31:0] dat);
    wbrx_adr_i = adr; wbrx_dat_i = dat; wbrx_cyc_i = 1'b1; wbrx_stb_i = 1'b1;
  endtask

  task automatic req_tx(input logic [31:0] adr);
    wbtx_adr_i = adr; wbtx_cyc_i = 1'b1; wbtx_stb_i = 1'b1;
  endtask

  task automatic req_cpu(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic push(input int port, input int exp_cyc, input bit chk, input logic [31:0] data);
    exp_t e;
    e.port = port; e.exp_cyc = exp_cyc; e.chk = chk; e.data = data;
    sb.push_back(e);
  endtask

  // Wait for n acks within a cycle budget, scoring each against the queue head.
  task automatic collect(input int n, input int budget);
    int   got;
    int   port;
    exp_t e;
    logic [2:0] acks;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge sys_clk);
      acks = {wb_ack_o, wbtx_ack_o, wbrx_ack_o};
      if (acks != 3'b000) begin
        check("ack_onehot", $countones(acks), 1);
        port = acks[0] ? 0 : (acks[1] ? 1 : 2);
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ack_port", port, e.port);
          check("ack_cycle", cyc_cnt, e.exp_cyc);
          if (e.chk) check(port == 1 ? "tx_data" : "cpu_data",
                           port == 1 ? wbtx_dat_o : wb_dat_o, e.data);
        end
        case (port)
          0:       begin wbrx_cyc_i = 1'b0; wbrx_stb_i = 1'b0; end
          1:       begin wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0; end
          default: begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; end
        endcase
        got++;
      end
    end
    if (got < n) begin
      check("ack_timeout", got, n);
      drop_all();
      sb.delete();
    end
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp);
    tick();
    req_cpu(we, adr, dat, sel);
    push(2, cyc_cnt + 2, !we, exp);
    collect(1, 10);
  endtask

  task automatic rx_op(input logic [31:0] adr, input logic [31:0] dat);
    tick();
    req_rx(adr, dat);
    push(0, cyc_cnt + 2, 1'b0, '0);
    collect(1, 10);
  endtask

  task automatic tx_op(input logic [31:0] adr, input logic [31:0] exp);
    tick();
    req_tx(adr);
    push(1, cyc_cnt + 2, 1'b1, exp);
    collect(1, 10);
  endtask

  // All three ports request in the same cycle; RX writes, TX and CPU read.
  task automatic all3(input logic [31:0] rx_adr, input logic [31:0] rx_dat,
                      input logic [31:0] tx_adr, input logic [31:0] tx_exp,
                      input logic [31:0] cpu_adr, input logic [31:0] cpu_exp);
    tick();
    req_rx(rx_adr, rx_dat);
    req_tx(tx_adr);
    req_cpu(1'b0, cpu_adr, 32'hFFFF_FFFF, 4'hF);
    push(0, cyc_cnt + 2, 1'b0, '0);
    push(1, cyc_cnt + 5, 1'b1, tx_exp);
    push(2, cyc_cnt + 8, 1'b1, cpu_exp);
    collect(3, 20);
  endtask

  task automatic do_reset;
    drop_all();
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    int t0;
    wbrx_adr_i = '0; wbrx_dat_i = '0; wbtx_adr_i = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    drop_all();
    do_reset();

    // Reset state.
    @(negedge sys_clk);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_acks", {wb_ack_o, wbtx_ack_o, wbrx_ack_o}, 0);
    check("rst_wb_dat", wb_dat_o, 0);
    check("rst_tx_dat", wbtx_dat_o, 0);

    // CPU full-word write/readback, then a read with junk write data must not
    // alter RAM.
    cpu_op(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, '0);
    cpu_op(1'b0, 32'h10, 32'h0BAD_0BAD, 4'hF, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h10, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF);

    // Byte-lane write.
    cpu_op(1'b1, 32'h20, 32'hAAAA_AAAA, 4'hF, '0);
    cpu_op(1'b1, 32'h20, 32'h1122_3344, 4'b0101, '0);
    cpu_op(1'b0, 32'h20, 32'h0, 4'hF, 32'hAA22_AA44);

    // Simultaneous requests right after reset: RX, TX, CPU at +2, +5, +8.
    do_reset();
    all3(32'h40, 32'h0BAD_F00D, 32'h10, 32'hDEAD_BEEF, 32'h20, 32'hAA22_AA44);

    // Each port's read data is held across the other port's reads.
    tx_op(32'h40, 32'h0BAD_F00D);
    check("cpu_dat_hold", wb_dat_o, 32'hAA22_AA44);
    cpu_op(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF);
    check("tx_dat_hold", wbtx_dat_o, 32'h0BAD_F00D);

    // Address aliasing: byte address 0x800 wraps to word 0.
    rx_op(32'h800, 32'hCAFE_F00D);
    tx_op(32'h0, 32'hCAFE_F00D);

    // CPU drops stb during ACCESS: write commits, no ack.
    tick();
    req_cpu(1'b1, 32'h30, 32'h5A5A_5A5A, 4'hF);
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("drop_no_ack", wb_ack_o, 0);
    end
    wb_we_i = 1'b0;
    cpu_op(1'b0, 32'h30, 32'h0, 4'hF, 32'h5A5A_5A5A);

    // Reset during ACCESS of a TX read: aborted, no ack, RX wins next.
    tick();
    req_tx(32'h10);
    t0 = cyc_cnt;
    tick();
    check("abort_in_access", 32'(dut.state), 32'(S_ACCESS));
    sys_rst = 1'b1;
    wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0;
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("abort_no_ack", wbtx_ack_o, 0);
      check("abort_state", 32'(dut.state), 32'(S_IDLE));
    end
    check("abort_tx_dat", wbtx_dat_o, 0);
    check("abort_cycles", cyc_cnt - t0, 4);
    all3(32'h44, 32'h7777_8888, 32'h10, 32'hDEAD_BEEF, 32'h30, 32'h5A5A_5A5A);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
